// File: rtl/mem_wb_skid_reg.sv
// rtl/mem_wb_skid_reg.sv - MEM/WB boundary as a two-entry skid buffer with valid/ready handshake
module mem_wb_skid_reg #(
   parameter int                 ADDR_W         = 30,
   parameter int                 DATA_W         = 32,
   parameter int                 REG_ADDR_W     = 5,
   parameter int                 CTRL_W         = 2,
   parameter int                 EXP_W          = 3,
   parameter logic [EXP_W-1:0]   EXP_MISS_ALIGN = EXP_W'(2),
   parameter int                 CNT_W          = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_W-1:0]     in_pc,
   input  logic                  in_en,
   input  logic                  in_br_flag,
   input  logic [CTRL_W-1:0]     in_ctrl_op,
   input  logic [REG_ADDR_W-1:0] in_dst_addr,
   input  logic                  in_gpr_we_,
   input  logic [EXP_W-1:0]      in_exp_code,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_miss_align,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_W-1:0]     out_pc,
   output logic                  out_en,
   output logic                  out_br_flag,
   output logic [CTRL_W-1:0]     out_ctrl_op,
   output logic [REG_ADDR_W-1:0] out_dst_addr,
   output logic                  out_gpr_we_,
   output logic [EXP_W-1:0]      out_exp_code,
   output logic [DATA_W-1:0]     out_data,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam int PAY_W = ADDR_W + 2 + CTRL_W + REG_ADDR_W + 1 + EXP_W + DATA_W;
   // Idle payload: everything zero except the active-low write enable.
   localparam logic [PAY_W-1:0] PAY_DEFAULT =
      {{(ADDR_W + 2 + CTRL_W + REG_ADDR_W){1'b0}}, 1'b1, {(EXP_W + DATA_W){1'b0}}};

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

   state_t           r_state;
   logic [PAY_W-1:0] r_main;
   logic [PAY_W-1:0] r_skid;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [PAY_W-1:0] w_cap;
   logic             w_accept;
   logic             w_pop;

   assign w_accept = in_valid & r_in_ready & ~flush;
   assign w_pop    = r_out_valid & out_ready & ~flush;

   // A misaligned access becomes a harmless exception entry: no GPR/control side effects.
   assign w_cap = in_miss_align
      ? {in_pc, in_en, in_br_flag, {CTRL_W{1'b0}}, {REG_ADDR_W{1'b0}}, 1'b1,
         EXP_MISS_ALIGN, {DATA_W{1'b0}}}
      : {in_pc, in_en, in_br_flag, in_ctrl_op, in_dst_addr, in_gpr_we_,
         in_exp_code, in_data};

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_state     <= S_EMPTY;
         r_main      <= PAY_DEFAULT;
         r_skid      <= PAY_DEFAULT;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  r_main      <= w_cap;
                  r_state     <= S_ONE;
                  r_out_valid <= 1'b1;
               end
            end
            S_ONE: begin
               if (w_accept && w_pop) begin
                  r_main <= w_cap;
               end else if (w_accept) begin
                  r_skid     <= w_cap;
                  r_state    <= S_TWO;
                  r_in_ready <= 1'b0;
               end else if (w_pop) begin
                  r_main      <= PAY_DEFAULT;
                  r_state     <= S_EMPTY;
                  r_out_valid <= 1'b0;
               end
            end
            S_TWO: begin
               if (w_pop) begin
                  r_main     <= r_skid;
                  r_skid     <= PAY_DEFAULT;
                  r_state    <= S_ONE;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_EMPTY;
               r_main      <= PAY_DEFAULT;
               r_skid      <= PAY_DEFAULT;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Counts WB back-pressure; survives flush so stalls stay visible across redirects.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (r_out_valid && !out_ready && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign stall_cnt = r_stall_cnt;
   assign {out_pc, out_en, out_br_flag, out_ctrl_op, out_dst_addr, out_gpr_we_,
           out_exp_code, out_data} = r_main;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// tb/tb_mem_wb_skid_reg.sv - self-checking bench for mem_wb_skid_reg against a queue model
module tb_mem_wb_skid_reg;

   typedef struct packed {
      logic [29:0] pc;
      logic        en;
      logic        br;
      logic [1:0]  ctrl;
      logic [4:0]  dst;
      logic        we_;
      logic [2:0]  exp;
      logic [31:0] data;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, flush, in_valid, in_en, in_br_flag, in_gpr_we_, in_miss_align, out_ready;
   logic [29:0] in_pc;
   logic [1:0]  in_ctrl_op;
   logic [4:0]  in_dst_addr;
   logic [2:0]  in_exp_code;
   logic [31:0] in_data;

   logic        in_ready, out_valid, out_en, out_br_flag, out_gpr_we_;
   logic [29:0] out_pc;
   logic [1:0]  out_ctrl_op;
   logic [4:0]  out_dst_addr;
   logic [2:0]  out_exp_code;
   logic [31:0] out_data;
   logic [15:0] stall_cnt;

   logic        b_in_ready, b_out_valid, b_out_en, b_out_br_flag, b_out_gpr_we_;
   logic [29:0] b_out_pc;
   logic [1:0]  b_out_ctrl_op;
   logic [4:0]  b_out_dst_addr;
   logic [2:0]  b_out_exp_code;
   logic [31:0] b_out_data;
   logic [3:0]  b_stall_cnt;

   mem_wb_skid_reg dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_en(in_en), .in_br_flag(in_br_flag), .in_ctrl_op(in_ctrl_op),
      .in_dst_addr(in_dst_addr), .in_gpr_we_(in_gpr_we_), .in_exp_code(in_exp_code),
      .in_data(in_data), .in_miss_align(in_miss_align), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_en(out_en), .out_br_flag(out_br_flag),
      .out_ctrl_op(out_ctrl_op), .out_dst_addr(out_dst_addr), .out_gpr_we_(out_gpr_we_),
      .out_exp_code(out_exp_code), .out_data(out_data), .stall_cnt(stall_cnt)
   );

   mem_wb_skid_reg #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_pc(in_pc), .in_en(in_en), .in_br_flag(in_br_flag), .in_ctrl_op(in_ctrl_op),
      .in_dst_addr(in_dst_addr), .in_gpr_we_(in_gpr_we_), .in_exp_code(in_exp_code),
      .in_data(in_data), .in_miss_align(in_miss_align), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_pc(b_out_pc), .out_en(b_out_en), .out_br_flag(b_out_br_flag),
      .out_ctrl_op(b_out_ctrl_op), .out_dst_addr(b_out_dst_addr), .out_gpr_we_(b_out_gpr_we_),
      .out_exp_code(b_out_exp_code), .out_data(b_out_data), .stall_cnt(b_stall_cnt)
   );

   int   n_checks = 0;
   int   n_err    = 0;
   ent_t q[$];
   int   cnt16, cnt4;
   ent_t ent_default;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic ent_t xform();
      ent_t e;
      e.pc = in_pc; e.en = in_en; e.br = in_br_flag;
      if (in_miss_align) begin
         e.ctrl = 0; e.dst = 0; e.we_ = 1'b1; e.exp = 3'd2; e.data = 0;
      end else begin
         e.ctrl = in_ctrl_op; e.dst = in_dst_addr; e.we_ = in_gpr_we_;
         e.exp = in_exp_code; e.data = in_data;
      end
      return e;
   endfunction

   task automatic check_all();
      ent_t expe;
      ent_t obs;
      expe = (q.size() > 0) ? q[0] : ent_default;
      obs  = {out_pc, out_en, out_br_flag, out_ctrl_op, out_dst_addr, out_gpr_we_,
              out_exp_code, out_data};
      chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
      chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
      chk("payload", 128'(obs), 128'(expe));
      chk("stall_cnt16", 128'(stall_cnt), 128'(cnt16));
      chk("stall_cnt4", 128'(b_stall_cnt), 128'(cnt4));
      chk("payload4", 128'({b_out_pc, b_out_en, b_out_br_flag, b_out_ctrl_op, b_out_dst_addr,
                            b_out_gpr_we_, b_out_exp_code, b_out_data}), 128'(expe));
   endtask

   // One clock: update the reference queue from pre-edge inputs, then compare after the edge.
   task automatic tick();
      bit rdy, vld;
      rdy = (q.size() < 2);
      vld = (q.size() > 0);
      @(posedge clk);
      if (reset) begin
         q.delete(); cnt16 = 0; cnt4 = 0;
      end else begin
         if (vld && !out_ready) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt4 < 15) cnt4++;
         end
         if (flush) q.delete();
         else begin
            if (vld && out_ready) void'(q.pop_front());
            if (in_valid && rdy) q.push_back(xform());
         end
      end
      #1;
      check_all();
   endtask

   task automatic drive(input logic v, input logic [29:0] pc, input logic [31:0] d,
                        input logic [4:0] dst, input logic we_, input logic [1:0] ctrl,
                        input logic ma);
      in_valid = v; in_pc = pc; in_data = d; in_dst_addr = dst; in_gpr_we_ = we_;
      in_ctrl_op = ctrl; in_miss_align = ma; in_en = 1'b1; in_br_flag = 1'b0; in_exp_code = 3'd0;
   endtask

   initial begin
      int ov_run;
      ent_default = '0;
      ent_default.we_ = 1'b1;
      cnt16 = 0; cnt4 = 0;
      reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 30'd0, 32'd0, 5'd0, 1'b1, 2'd0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_stall", 128'(stall_cnt), 128'(0));

      // single entry
      drive(1'b1, 30'h100, 32'hDEADBEEF, 5'd5, 1'b0, 2'd0, 1'b0);
      tick();
      chk("single_data", 128'(out_data), 128'(32'hDEADBEEF));
      chk("single_dst", 128'(out_dst_addr), 128'(5));
      in_valid = 1'b0;
      tick();
      chk("single_popped_data", 128'(out_data), 128'(0));

      // misaligned access
      drive(1'b1, 30'h44, 32'h55, 5'd7, 1'b0, 2'd1, 1'b1);
      tick();
      chk("ma_exp", 128'(out_exp_code), 128'(2));
      chk("ma_we", 128'(out_gpr_we_), 128'(1));
      chk("ma_pc", 128'(out_pc), 128'(30'h44));
      in_valid = 1'b0;
      tick();

      // skid fill then drain
      out_ready = 1'b0;
      drive(1'b1, 30'd1, 32'd11, 5'd1, 1'b0, 2'd0, 1'b0); tick();
      drive(1'b1, 30'd2, 32'd22, 5'd2, 1'b0, 2'd0, 1'b0); tick();
      chk("skid_full_ready", 128'(in_ready), 128'(0));
      drive(1'b1, 30'd3, 32'd33, 5'd3, 1'b0, 2'd0, 1'b0); tick();
      tick();
      chk("skid_head_stable", 128'(out_pc), 128'(1));
      chk("skid_stall", 128'(stall_cnt), 128'(3));
      out_ready = 1'b1;
      tick();
      chk("drain_pc2", 128'(out_pc), 128'(2));
      tick();
      chk("drain_pc3", 128'(out_pc), 128'(3));
      in_valid = 1'b0;
      tick();

      // flush while two entries held
      out_ready = 1'b0;
      drive(1'b1, 30'd10, 32'd1, 5'd1, 1'b0, 2'd0, 1'b0); tick();
      drive(1'b1, 30'd11, 32'd2, 5'd1, 1'b0, 2'd0, 1'b0); tick();
      drive(1'b1, 30'd12, 32'd3, 5'd1, 1'b0, 2'd0, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 128'(out_valid), 128'(0));
      chk("flush_ready", 128'(in_ready), 128'(1));
      chk("flush_we", 128'(out_gpr_we_), 128'(1));
      out_ready = 1'b1;
      tick();
      chk("flush_dropped", 128'(out_valid), 128'(0));

      // full-rate stream
      ov_run = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 30'(200 + i), 32'(i), 5'd4, 1'b0, 2'd0, 1'b0);
         tick();
         if (out_valid) ov_run++;
      end
      in_valid = 1'b0;
      tick();
      chk("stream_no_bubbles", 128'(ov_run), 128'(8));

      // saturation on the narrow counter, then reset
      drive(1'b1, 30'd77, 32'd7, 5'd7, 1'b0, 2'd0, 1'b0);
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_cnt4", 128'(b_stall_cnt), 128'(15));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("sat_reset_cnt", 128'(b_stall_cnt), 128'(0));
      chk("sat_reset_valid", 128'(out_valid), 128'(0));

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         in_valid      = ($urandom_range(0, 3) != 0);
         out_ready     = ($urandom_range(0, 2) != 0);
         flush         = ($urandom_range(0, 31) == 0);
         reset         = ($urandom_range(0, 127) == 0);
         in_pc         = 30'($urandom);
         in_en         = 1'($urandom);
         in_br_flag    = 1'($urandom);
         in_ctrl_op    = 2'($urandom);
         in_dst_addr   = 5'($urandom);
         in_gpr_we_    = 1'($urandom);
         in_exp_code   = 3'($urandom);
         in_data       = $urandom;
         in_miss_align = ($urandom_range(0, 5) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_wb_skid_reg.md
# mem_wb_skid_reg

Parametrised MEM/WB pipeline boundary for the CPU core, replacing a single stall/flush register with a two-entry elastic (skid) buffer under a valid/ready handshake. Captures the MEM-stage payload: PC, branch flag, control-register op, GPR write request, exception code, load data. Misaligned accesses are converted into a miss-align exception at capture time. The block sits between the memory-access stage and write-back/control-register logic, so back-pressure from WB no longer needs a global combinational stall.

## Interface
Parameters (name, default, meaning):
- ADDR_W, 30, PC width (word address)
- DATA_W, 32, load/ALU result width
- REG_ADDR_W, 5, GPR address width
- CTRL_W, 2, control-register op width; op 0 = NOP
- EXP_W, 3, exception code width; 0 = no exception
- EXP_MISS_ALIGN, 3'h2, code substituted on misalignment
- CNT_W, 16, stall-counter width

Ports (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, reset; synchronous, active-high
- flush, in, 1, discard all held and incoming entries
- in_valid, in, 1, upstream entry present
- in_ready, out, 1, buffer can accept
- in_pc, in, ADDR_W, pc
- in_en, in, 1, pipeline-enable bit
- in_br_flag, in, 1, branch-delay flag
- in_ctrl_op, in, CTRL_W, control-register op
- in_dst_addr, in, REG_ADDR_W, GPR write address
- in_gpr_we_, in, 1, GPR write enable, active-low
- in_exp_code, in, EXP_W, upstream exception code
- in_data, in, DATA_W, memory/ALU result
- in_miss_align, in, 1, access misaligned
- out_valid, out, 1, entry presented to WB
- out_ready, in, 1, WB consumes
- out_pc, out_en, out_br_flag, out_ctrl_op, out_dst_addr, out_gpr_we_, out_exp_code, out_data, out, matching widths, head-entry fields
- stall_cnt, out, CNT_W, saturating count of back-pressured cycles

## Operation
- accept = in_valid & in_ready & ~flush. pop = out_valid & out_ready & ~flush.
- Capture transform when in_miss_align=1:
  - ctrl_op forced to 0, dst_addr to 0, gpr_we_ to 1, data to 0.
  - exp_code forced to EXP_MISS_ALIGN.
  - pc, en and br_flag pass through unchanged.
- Otherwise all fields are captured verbatim.
- Storage: main register (drives out_*) plus skid register. States:
  - EMPTY: 0 entries.
  - ONE: main valid.
  - TWO: main and skid valid.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept & ~pop → TWO; the new entry goes to skid.
  - ONE + pop & ~accept → EMPTY.
  - ONE + accept & pop → ONE; main is loaded with the new entry.
  - TWO + pop → ONE; skid moves to main.
  - TWO never accepts.
- in_ready = (state != TWO); a registered decode with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Whenever main becomes empty or is flushed, out_* fields return to defaults: pc 0, en 0, br 0, ctrl 0, dst 0, gpr_we_ 1, exp 0, data 0. The skid register is cleared likewise.
- flush has priority over everything. Next state is EMPTY, both entries are cleared, and any in_valid that cycle is dropped.
- stall_cnt increments by 1 each cycle with out_valid & ~out_ready and saturates at all-ones. It is cleared only by reset; flush does not clear it.

## Timing
- Reset (synchronous): state EMPTY, out_valid 0, all out_* at defaults, stall_cnt 0. in_ready = 1 from the first cycle after reset deassertion.
- Latency: one cycle. An entry accepted at edge N is on out_* with out_valid=1 after edge N. With out_ready held high it retires at edge N+1.
- Throughput: one entry per cycle with out_ready continuously high. Zero bubbles under a simultaneous accept and pop.
- Back-pressure: after the first cycle with out_ready=0, in_ready stays 1 for one more accept (the skid), then drops. No entry is lost or duplicated.
- out_* are stable while out_valid=1 and out_ready=0.
- Reset mid-operation: both entries are discarded at the next edge, regardless of flush or handshake inputs.

## Test plan
- Reset then single entry: in_pc=0x100, in_data=0xDEADBEEF, gpr_we_=0, dst=5 → after 1 edge out_valid=1 with identical fields; after pop, out_valid=0 and out_data=0.
- Miss-align: in_miss_align=1, ctrl_op=1, dst=7, gpr_we_=0, data=0x55 → out_exp_code=2, ctrl_op=0, dst=0, gpr_we_=1, data=0, pc unchanged.
- Skid fill: stream pc 1,2,3 with out_ready=0 → in_ready=0 after pc 2 is accepted and pc 3 is held. Release out_ready → outputs 1, 2, then 3 in order; stall_cnt equals the held cycles.
- Flush in TWO with in_valid=1 → next cycle out_valid=0, in_ready=1, all outputs at defaults, incoming entry absent from the output stream.
- Full-rate stream of 8 entries, out_ready=1 → 8 consecutive out_valid cycles, in order, no bubbles.
- Saturation with CNT_W=4: out_ready=0 for 20 cycles with an entry held → stall_cnt=15; then assert reset → stall_cnt=0 and out_valid=0.
